// File: rtl/inorder_queue_ptr_ctrl_pkg.sv
// ============================================================================
// Module   : inorder_queue_pkg
// Brief    : Pointer arithmetic helpers shared by the in-order queue pointer
//            controller (wrapping add, occupancy distance, population count).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package inorder_queue_pkg;

    localparam int unsigned PTR_CALC_W         = 32;
    localparam int unsigned DEF_QUEUE_SIZE_LOG = 4;

    typedef logic [PTR_CALC_W-1:0]       calc_t;
    typedef logic [DEF_QUEUE_SIZE_LOG:0] def_ptr_t;

    // Mask covering the index field plus the wrap bit.
    function automatic calc_t ptr_mask(input int unsigned qlog);
        return (calc_t'(1) << (qlog + 1)) - calc_t'(1);
    endfunction

    function automatic calc_t ptr_add(input calc_t a, input calc_t b, input int unsigned qlog);
        return (a + b) & ptr_mask(qlog);
    endfunction

    function automatic calc_t ptr_dist(input calc_t tail, input calc_t head, input int unsigned qlog);
        return (tail - head) & ptr_mask(qlog);
    endfunction

    function automatic calc_t popcount(input calc_t v);
        calc_t c;
        c = '0;
        for (int i = 0; i < int'(PTR_CALC_W); i++) begin
            c = c + calc_t'(v[i]);
        end
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ptr_onehot_dec.sv
// ============================================================================
// Module   : ptr_onehot_dec
// Brief    : Decodes a queue index into a QUEUE_SIZE-wide one-hot, gated by valid.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ptr_onehot_dec #(
    parameter int unsigned QUEUE_SIZE     = 16,
    parameter int unsigned QUEUE_SIZE_LOG = 4
) (
    input  logic [QUEUE_SIZE_LOG-1:0] i_idx,
    input  logic                      i_valid,
    output logic [QUEUE_SIZE-1:0]     o_oh
);

    for (genvar s = 0; s < int'(QUEUE_SIZE); s++) begin : g_slot
        assign o_oh[s] = i_valid && (i_idx == QUEUE_SIZE_LOG'(s));
    end

endmodule

`default_nettype wire

// File: rtl/inorder_queue_ptr_ctrl.sv
// ============================================================================
// Module   : inorder_queue_ptr_ctrl
// Brief    : Multi-lane head/tail pointer controller for in-order queues.
//            Optional perf counters enabled by INORDER_QUEUE_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inorder_queue_ptr_ctrl
    import inorder_queue_pkg::*;
#(
    parameter int unsigned QUEUE_SIZE     = 16,
    parameter int unsigned QUEUE_SIZE_LOG = 4,
    parameter int unsigned ENQ_WIDTH      = 2,
    parameter int unsigned DEQ_WIDTH      = 2
) (
    input  logic                                    clock,
    input  logic                                    reset_n,
    input  logic                                    flush_valid,
    input  logic [QUEUE_SIZE_LOG:0]                 flush_sqid,
    input  logic [ENQ_WIDTH-1:0]                    enq_req,
    output logic                                    enq_ready,
    output logic [ENQ_WIDTH*(QUEUE_SIZE_LOG+1)-1:0] enq_lane_ptr,
    output logic [QUEUE_SIZE-1:0]                   enq_alloc_oh,
    input  logic [DEQ_WIDTH-1:0]                    deq_fire,
    output logic [QUEUE_SIZE_LOG:0]                 enq_ptr,
    output logic [QUEUE_SIZE_LOG:0]                 deq_ptr,
    output logic [QUEUE_SIZE-1:0]                   deq_ptr_oh,
    output logic [QUEUE_SIZE_LOG:0]                 count,
    output logic                                    full,
    output logic                                    empty
`ifdef INORDER_QUEUE_PERF_EN
    ,
    output logic [31:0]                             perf_stall_cnt,
    output logic [31:0]                             perf_flush_cnt
`endif
);

    localparam int unsigned c_PTR_W = QUEUE_SIZE_LOG + 1;

    typedef logic [QUEUE_SIZE_LOG:0] ptr_t;

    ptr_t                  r_enq_ptr;
    ptr_t                  r_deq_ptr;
    ptr_t                  w_count;
    calc_t                 w_free;
    calc_t                 w_enq_total;
    calc_t                 w_deq_total;
    logic                  w_enq_fire;
    ptr_t                  w_lane_ptr [ENQ_WIDTH];
    logic [QUEUE_SIZE-1:0] w_lane_oh  [ENQ_WIDTH];

    assign w_count   = ptr_t'(ptr_dist(calc_t'(r_enq_ptr), calc_t'(r_deq_ptr), QUEUE_SIZE_LOG));
    assign w_free    = calc_t'(QUEUE_SIZE) - calc_t'(w_count);
    // Readiness uses the current occupancy, so a same-cycle dequeue never unblocks enqueue.
    assign enq_ready = (w_free >= calc_t'(ENQ_WIDTH));

    assign w_enq_total = popcount(calc_t'(enq_req));
    assign w_deq_total = popcount(calc_t'(deq_fire));
    assign w_enq_fire  = enq_ready && (enq_req != '0);

    for (genvar i = 0; i < int'(ENQ_WIDTH); i++) begin : g_lane
        localparam calc_t c_LOW_MASK = (calc_t'(1) << i) - calc_t'(1);

        assign w_lane_ptr[i] = ptr_t'(ptr_add(calc_t'(r_enq_ptr),
                                              popcount(calc_t'(enq_req) & c_LOW_MASK),
                                              QUEUE_SIZE_LOG));
        assign enq_lane_ptr[i*c_PTR_W +: c_PTR_W] = w_lane_ptr[i];

        ptr_onehot_dec #(
            .QUEUE_SIZE     (QUEUE_SIZE),
            .QUEUE_SIZE_LOG (QUEUE_SIZE_LOG)
        ) u_lane_dec (
            .i_idx   (w_lane_ptr[i][QUEUE_SIZE_LOG-1:0]),
            .i_valid (enq_req[i] && enq_ready),
            .o_oh    (w_lane_oh[i])
        );
    end

    always_comb begin
        enq_alloc_oh = '0;
        for (int i = 0; i < int'(ENQ_WIDTH); i++) begin
            enq_alloc_oh = enq_alloc_oh | w_lane_oh[i];
        end
    end

    ptr_onehot_dec #(
        .QUEUE_SIZE     (QUEUE_SIZE),
        .QUEUE_SIZE_LOG (QUEUE_SIZE_LOG)
    ) u_deq_dec (
        .i_idx   (r_deq_ptr[QUEUE_SIZE_LOG-1:0]),
        .i_valid (1'b1),
        .o_oh    (deq_ptr_oh)
    );

    // Flush rolls the tail back and overrides any enqueue in the same cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_enq_ptr <= '0;
            r_deq_ptr <= '0;
        end else begin
            if (flush_valid) begin
                r_enq_ptr <= flush_sqid;
            end else if (w_enq_fire) begin
                r_enq_ptr <= ptr_t'(ptr_add(calc_t'(r_enq_ptr), w_enq_total, QUEUE_SIZE_LOG));
            end
            r_deq_ptr <= ptr_t'(ptr_add(calc_t'(r_deq_ptr), w_deq_total, QUEUE_SIZE_LOG));
        end
    end

    assign enq_ptr = r_enq_ptr;
    assign deq_ptr = r_deq_ptr;
    assign count   = w_count;
    assign full    = (r_enq_ptr[QUEUE_SIZE_LOG-1:0] == r_deq_ptr[QUEUE_SIZE_LOG-1:0]) &&
                     (r_enq_ptr[QUEUE_SIZE_LOG] != r_deq_ptr[QUEUE_SIZE_LOG]);
    assign empty   = (r_enq_ptr == r_deq_ptr);

`ifdef INORDER_QUEUE_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if ((enq_req != '0) && !enq_ready && !flush_valid && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (flush_valid && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = r_stall_cnt;
    assign perf_flush_cnt = r_flush_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_inorder_queue_ptr_ctrl.sv
// ============================================================================
// Module   : tb_inorder_queue_ptr_ctrl
// Brief    : Directed self-checking bench with a cycle model of the queue pointers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inorder_queue_ptr_ctrl;

    logic        clock;
    logic        reset_n;
    logic        flush_valid;
    logic [4:0]  flush_sqid;
    logic [1:0]  enq_req;
    logic        enq_ready;
    logic [9:0]  enq_lane_ptr;
    logic [15:0] enq_alloc_oh;
    logic [1:0]  deq_fire;
    logic [4:0]  enq_ptr;
    logic [4:0]  deq_ptr;
    logic [15:0] deq_ptr_oh;
    logic [4:0]  count;
    logic        full;
    logic        empty;
`ifdef INORDER_QUEUE_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    int n_chk;
    int n_fail;

    inorder_queue_ptr_ctrl #(
        .QUEUE_SIZE     (16),
        .QUEUE_SIZE_LOG (4),
        .ENQ_WIDTH      (2),
        .DEQ_WIDTH      (2)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .flush_valid  (flush_valid),
        .flush_sqid   (flush_sqid),
        .enq_req      (enq_req),
        .enq_ready    (enq_ready),
        .enq_lane_ptr (enq_lane_ptr),
        .enq_alloc_oh (enq_alloc_oh),
        .deq_fire     (deq_fire),
        .enq_ptr      (enq_ptr),
        .deq_ptr      (deq_ptr),
        .deq_ptr_oh   (deq_ptr_oh),
        .count        (count),
        .full         (full),
        .empty        (empty)
`ifdef INORDER_QUEUE_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: head and tail as plain integers modulo twice the queue size.
    int m_tail;
    int m_head;
    int m_stall;
    int m_flush;

    function automatic int m_count();
        return (m_tail - m_head + 32) % 32;
    endfunction

    function automatic bit m_ready();
        return (16 - m_count()) >= 2;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_tail  <= 0;
            m_head  <= 0;
            m_stall <= 0;
            m_flush <= 0;
        end else begin
            if (flush_valid)
                m_tail <= int'(flush_sqid);
            else if (m_ready() && enq_req != 2'b00)
                m_tail <= (m_tail + $countones(enq_req)) % 32;
            m_head <= (m_head + $countones(deq_fire)) % 32;
            if (enq_req != 2'b00 && !m_ready() && !flush_valid) m_stall <= m_stall + 1;
            if (flush_valid) m_flush <= m_flush + 1;
        end
    end

    always @(negedge clock) begin
        int          pre;
        logic [31:0] e_lane;
        logic [31:0] e_alloc;
        pre     = 0;
        e_lane  = '0;
        e_alloc = '0;
        for (int i = 0; i < 2; i++) begin
            int p;
            p      = (m_tail + pre) % 32;
            e_lane = e_lane | (32'(p) << (i * 5));
            if (enq_req[i] && m_ready()) e_alloc = e_alloc | (32'd1 << (p % 16));
            if (enq_req[i]) pre++;
        end
        chk("m_enq_ptr",    32'(enq_ptr),      32'(m_tail));
        chk("m_deq_ptr",    32'(deq_ptr),      32'(m_head));
        chk("m_count",      32'(count),        32'(m_count()));
        chk("m_full",       32'(full),         32'(m_count() == 16));
        chk("m_empty",      32'(empty),        32'(m_count() == 0));
        chk("m_enq_ready",  32'(enq_ready),    32'(m_ready()));
        chk("m_lane_ptr",   32'(enq_lane_ptr), e_lane);
        chk("m_alloc_oh",   32'(enq_alloc_oh), e_alloc);
        chk("m_deq_ptr_oh", 32'(deq_ptr_oh),   32'd1 << (m_head % 16));
`ifdef INORDER_QUEUE_PERF_EN
        chk("m_perf_stall", perf_stall_cnt,    32'(m_stall));
        chk("m_perf_flush", perf_flush_cnt,    32'(m_flush));
`endif
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [1:0] req, input logic [1:0] deq,
                         input logic fv, input logic [4:0] sq);
        enq_req     = req;
        deq_fire    = deq;
        flush_valid = fv;
        flush_sqid  = sq;
    endtask

    task automatic do_reset();
        drive(2'b00, 2'b00, 1'b0, 5'd0);
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;
        cyc();
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        drive(2'b00, 2'b00, 1'b0, 5'd0);
        #12;
        chk("rst_enq_ptr",   32'(enq_ptr),    32'd0);
        chk("rst_deq_ptr",   32'(deq_ptr),    32'd0);
        chk("rst_count",     32'(count),      32'd0);
        chk("rst_empty",     32'(empty),      32'd1);
        chk("rst_full",      32'(full),       32'd0);
        chk("rst_ready",     32'(enq_ready),  32'd1);
        chk("rst_deq_oh",    32'(deq_ptr_oh), 32'd1);
        reset_n = 1'b1;
        cyc();

        // Fill the queue two entries per cycle.
        for (int k = 0; k < 8; k++) begin
            drive(2'b11, 2'b00, 1'b0, 5'd0);
            #1;
            if (k == 7) chk("fill_lane_ptr", 32'(enq_lane_ptr), 32'd494);
            cyc();
        end
        drive(2'b00, 2'b00, 1'b0, 5'd0);
        #1;
        chk("fill_enq_ptr", 32'(enq_ptr),   32'd16);
        chk("fill_count",   32'(count),     32'd16);
        chk("fill_full",    32'(full),      32'd1);
        chk("fill_ready",   32'(enq_ready), 32'd0);

        // Dequeue one at full while requesting: enqueue must stall.
        drive(2'b11, 2'b01, 1'b0, 5'd0);
        cyc();
        drive(2'b00, 2'b00, 1'b0, 5'd0);
        #1;
        chk("stall_count", 32'(count),     32'd15);
        chk("stall_ready", 32'(enq_ready), 32'd0);
        drive(2'b00, 2'b01, 1'b0, 5'd0);
        cyc();
        drive(2'b00, 2'b00, 1'b0, 5'd0);
        #1;
        chk("free2_count", 32'(count),     32'd14);
        chk("free2_ready", 32'(enq_ready), 32'd1);
`ifdef INORDER_QUEUE_PERF_EN
        chk("perf_stall_lit", perf_stall_cnt, 32'd1);
`endif

        // Wrap-around allocation: tail 15, head 10.
        do_reset();
        for (int k = 0; k < 7; k++) begin
            drive(2'b11, 2'b00, 1'b0, 5'd0);
            cyc();
        end
        drive(2'b01, 2'b00, 1'b0, 5'd0);
        cyc();
        for (int k = 0; k < 5; k++) begin
            drive(2'b00, 2'b11, 1'b0, 5'd0);
            cyc();
        end
        drive(2'b11, 2'b00, 1'b0, 5'd0);
        #1;
        chk("wrap_deq_ptr",  32'(deq_ptr),      32'd10);
        chk("wrap_lane_ptr", 32'(enq_lane_ptr), 32'd527);
        chk("wrap_alloc_oh", 32'(enq_alloc_oh), 32'h8001);
        cyc();
        drive(2'b10, 2'b00, 1'b0, 5'd0);
        #1;
        chk("wrap_enq_ptr",   32'(enq_ptr),           32'd17);
        chk("lane1_only_ptr", 32'(enq_lane_ptr[9:5]), 32'd17);
        chk("lane1_only_oh",  32'(enq_alloc_oh),      32'h0002);
        cyc();
        drive(2'b00, 2'b00, 1'b0, 5'd0);
        #1;
        chk("lane1_only_enq", 32'(enq_ptr), 32'd18);

        // Flush with simultaneous enqueue and dequeue.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive(2'b11, 2'b00, 1'b0, 5'd0);
            cyc();
        end
        for (int k = 0; k < 2; k++) begin
            drive(2'b00, 2'b11, 1'b0, 5'd0);
            cyc();
        end
        drive(2'b11, 2'b11, 1'b1, 5'd7);
        cyc();
        drive(2'b00, 2'b00, 1'b0, 5'd0);
        #1;
        chk("flush_enq_ptr", 32'(enq_ptr), 32'd7);
        chk("flush_deq_ptr", 32'(deq_ptr), 32'd6);
        chk("flush_count",   32'(count),   32'd1);
`ifdef INORDER_QUEUE_PERF_EN
        chk("perf_flush_lit", perf_flush_cnt, 32'd1);
`endif

        // Asynchronous reset in the middle of an enqueue burst.
        for (int k = 0; k < 3; k++) begin
            drive(2'b11, 2'b01, 1'b0, 5'd0);
            cyc();
        end
        #1;
        reset_n = 1'b0;
        #1;
        chk("arst_enq_ptr", 32'(enq_ptr), 32'd0);
        chk("arst_deq_ptr", 32'(deq_ptr), 32'd0);
        chk("arst_empty",   32'(empty),   32'd1);
        chk("arst_count",   32'(count),   32'd0);
`ifdef INORDER_QUEUE_PERF_EN
        chk("arst_perf_stall", perf_stall_cnt, 32'd0);
        chk("arst_perf_flush", perf_flush_cnt, 32'd0);
`endif
        cyc();
        drive(2'b00, 2'b00, 1'b0, 5'd0);
        reset_n = 1'b1;
        cyc();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/inorder_queue_ptr_ctrl.md
Name: inorder_queue_ptr_ctrl

Overview:
- Multi-lane head/tail pointer controller for in-order queues (store queue, load queue).
- Allocates up to ENQ_WIDTH slots and retires up to DEQ_WIDTH slots per cycle.
- Rolls the tail back on flush.
- Supplies per-lane wrapped pointers, one-hot masks, occupancy and full/empty flags to the queue datapath.

Parameters:
- QUEUE_SIZE, 16, number of entries; power of two.
- QUEUE_SIZE_LOG, 4, log2(QUEUE_SIZE); pointers are QUEUE_SIZE_LOG+1 bits, MSB is the wrap bit.
- ENQ_WIDTH, 2, enqueue lanes per cycle; ≤ QUEUE_SIZE.
- DEQ_WIDTH, 2, dequeue lanes per cycle; ≤ QUEUE_SIZE.

Ports:
- clock  in  1  single clock.
- reset_n  in  1  asynchronous active-low reset.
- flush_valid  in  1  redirect; rolls back the tail.
- flush_sqid  in  QUEUE_SIZE_LOG+1  new tail pointer (first freed slot, wrap bit included).
- enq_req  in  ENQ_WIDTH  per-lane allocation request; any bit pattern allowed.
- enq_ready  out  1  free slots ≥ ENQ_WIDTH.
- enq_lane_ptr  out  ENQ_WIDTH*(QUEUE_SIZE_LOG+1)  pointer granted to each lane, lane 0 in LSBs.
- enq_alloc_oh  out  QUEUE_SIZE  slots written this cycle, gated by enq_ready.
- deq_fire  in  DEQ_WIDTH  retire mask; must be a contiguous prefix from bit 0.
- enq_ptr  out  QUEUE_SIZE_LOG+1  tail.
- deq_ptr  out  QUEUE_SIZE_LOG+1  head.
- deq_ptr_oh  out  QUEUE_SIZE  one-hot of deq_ptr index.
- count  out  QUEUE_SIZE_LOG+1  occupancy, 0..QUEUE_SIZE.
- full  out  1  count == QUEUE_SIZE.
- empty  out  1  count == 0.

Behaviour:
- Reset (async, reset_n low): enq_ptr=0, deq_ptr=0, count=0, empty=1, full=0, enq_ready=1, deq_ptr_oh=1.
- Reset mid-operation drops all state immediately, regardless of pending requests.
- Lane pointers (combinational): lane i gets enq_ptr + popcount(enq_req[i-1:0]), mod 2^(QUEUE_SIZE_LOG+1). Non-requesting lanes still show this value; the datapath ignores it.
- Enqueue is all-or-nothing: fire = enq_ready and (enq_req != 0). On fire, enq_ptr += popcount(enq_req) at the next edge. No partial grants.
- enq_alloc_oh: bit at the index of each requesting lane's pointer when enq_ready=1, else all zero. Index wrap-around is handled (e.g. slots 15 and 0).
- Dequeue: deq_ptr += popcount(deq_fire) at the next edge.
- Illegal input, undefined result: non-prefix deq_fire, or retiring more entries than count.
- Flush has priority over enqueue: enq_ptr <= flush_sqid and enq_req is ignored that cycle. deq_fire in the same cycle still advances deq_ptr.
- Legal flush_sqid lies between the post-dequeue deq_ptr and the current enq_ptr, inclusive (wrap-aware).
- Occupancy: count = enq_ptr - deq_ptr, wrap-bit arithmetic. Computed combinationally from the registered pointers; no extra count register.
- Full: index fields equal and wrap bits differ. Empty: pointers fully equal.
- Simultaneous enq+deq at full: enq_ready=0 (decided from the current count), so enqueue stalls even though a slot frees this cycle.
- All outputs are registered pointers or combinational functions of them and inputs. Latency: allocation visible in enq_ptr one cycle after fire.

Optional Feature:
- Macro: INORDER_QUEUE_PERF_EN.
- Defined: adds output perf_stall_cnt (32-bit) and perf_flush_cnt (32-bit), both reset to 0.
  - perf_stall_cnt increments each cycle with enq_req!=0, enq_ready=0 and flush_valid=0. Saturates at all-ones.
  - perf_flush_cnt increments per flush_valid cycle. Saturates at all-ones.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Package inorder_queue_pkg:
  - ptr_add function (wrapping add with wrap bit).
  - ptr_dist function (occupancy).
  - popcount function.
  - typedef pattern for pointer width, parameterised by QUEUE_SIZE_LOG.
- Sub-module ptr_onehot_dec: decodes a pointer index to a QUEUE_SIZE one-hot with a valid gate. Instantiated ENQ_WIDTH+1 times: enqueue lanes are ORed into enq_alloc_oh; one instance drives deq_ptr_oh.

Test Plan:
- Reset then enq_req=2'b11 for 8 cycles, no deq -> enq_ptr=5'b10000, count=16, full=1, enq_ready=0; enq_lane_ptr at cycle 7 = {15,14}.
- From full, deq_fire=2'b01 plus enq_req=2'b11 same cycle -> enqueue stalls, count=15, enq_ready=0. Next cycle deq_fire=2'b01 again -> count=14, enq_ready=1.
- enq_ptr=15, deq_ptr=10, enq_req=2'b11 -> enq_lane_ptr={16,15}, enq_alloc_oh=0x8001, enq_ptr=17 next cycle.
- enq_ptr=12, deq_ptr=4, flush_valid with flush_sqid=7, enq_req=2'b11, deq_fire=2'b11 -> enq_ptr=7, deq_ptr=6, count=1.
- enq_req=2'b10 only -> lane1 pointer = enq_ptr, enq_alloc_oh has one bit, enq_ptr +1.
- Assert reset_n low mid-burst with enqueues in flight -> all pointers 0, empty=1 asynchronously. With INORDER_QUEUE_PERF_EN: counters read 0 and perf_stall_cnt counts exactly the stalled cycles from scenario 2.
